// File: rtl/psram_responder.sv
// psram_responder
//   Behavioural responder for an asynchronous address/data-multiplexed PSRAM
//   (CellularRAM-style) bus. It latches the address on cram_adv_n and serves
//   reads from an internal word store. Writes are collected and then
//   committed with byte enables when the chip is deselected. It also counts
//   completed transactions and flags bus protocol violations.
//
// Ports
//   clk, reset             single clock, synchronous active-high reset
//   cram_a                 upper address bits [ADDRESS_BITS-2:DATA_BITS]
//   cram_dq                muxed low address (adv_n low) / data (inout)
//   cram_adv_n, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n,
//   cram_ub_n, cram_lb_n   active-low bus strobes
//   cram_clk, cram_cre     unused (async mode only)
//   cram_wait              always 0
//   rd_count, wr_count     completed read / write transactions (wrap)
//   proto_err              sticky protocol-violation flag
module psram_responder #(
  parameter int ADDRESS_BITS  = 23,
  parameter int DATA_BITS     = 16,
  parameter int MEM_ADDR_BITS = 10,
  parameter int READ_LATENCY  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDRESS_BITS-2:DATA_BITS] cram_a,
  inout  wire logic [DATA_BITS-1:0]      cram_dq,
  input  logic                           cram_adv_n,
  input  logic                           cram_ce0_n,
  input  logic                           cram_ce1_n,
  input  logic                           cram_oe_n,
  input  logic                           cram_we_n,
  input  logic                           cram_ub_n,
  input  logic                           cram_lb_n,
  input  logic                           cram_clk,
  input  logic                           cram_cre,
  output logic                           cram_wait,
  output logic [15:0]                    rd_count,
  output logic [15:0]                    wr_count,
  output logic                           proto_err
);

  localparam int LW = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [LW-1:0] LAT_MAX = LW'(READ_LATENCY);
  localparam int HB = DATA_BITS / 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                     state_q, state_d;
  logic [MEM_ADDR_BITS-1:0]   addr_q, addr_d;
  logic [LW-1:0]              lat_q, lat_d;
  logic                       dq_oe_q, dq_oe_d;
  logic                       pend_valid_q, pend_valid_d;
  logic [DATA_BITS-1:0]       pend_data_q, pend_data_d;
  logic                       pend_ub_n_q, pend_ub_n_d;
  logic                       pend_lb_n_q, pend_lb_n_d;
  logic [15:0]                rd_count_q, rd_count_d;
  logic [15:0]                wr_count_q, wr_count_d;
  logic                       proto_q, proto_d;
  logic                       mem_we;

  logic [DATA_BITS-1:0]       mem [2**MEM_ADDR_BITS];

  logic                       sel;
  logic                       violation;
  logic [ADDRESS_BITS-1:0]    full_addr;

  // Exactly one CE low selects the chip; ce1 selects the upper bank.
  assign sel       = cram_ce0_n ^ cram_ce1_n;
  assign full_addr = {~cram_ce1_n, cram_a, cram_dq};

  assign violation = (!cram_ce0_n && !cram_ce1_n)
                   || (sel && !cram_oe_n && !cram_we_n)
                   || (state_q == WRITE && !cram_oe_n);

  // Bank bit and upper address bits alias onto the smaller store.
  logic unused_ok;
  assign unused_ok = &{1'b0, cram_clk, cram_cre,
                       full_addr[ADDRESS_BITS-1:MEM_ADDR_BITS]};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lat_d        = lat_q;
    dq_oe_d      = dq_oe_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_ub_n_d  = pend_ub_n_q;
    pend_lb_n_d  = pend_lb_n_q;
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
    proto_d      = proto_q | violation;
    mem_we       = 1'b0;

    if (sel && !cram_adv_n) begin
      // A new address phase restarts the transaction from any state.
      addr_d       = full_addr[MEM_ADDR_BITS-1:0];
      state_d      = cram_we_n ? READ : WRITE;
      lat_d        = '0;
      dq_oe_d      = 1'b0;
      pend_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        READ: begin
          if (!sel) begin
            if (dq_oe_q) rd_count_d = rd_count_q + 16'd1;
            state_d = IDLE;
            dq_oe_d = 1'b0;
          end else if (!cram_oe_n) begin
            if (lat_q != LAT_MAX) lat_d = lat_q + 1'b1;
            if (lat_d == LAT_MAX) dq_oe_d = 1'b1;
          end
        end
        WRITE: begin
          if (!sel) begin
            if (pend_valid_q) begin
              mem_we     = 1'b1;
              wr_count_d = wr_count_q + 16'd1;
            end
            state_d      = IDLE;
            pend_valid_d = 1'b0;
          end else if (cram_adv_n && !cram_we_n) begin
            pend_valid_d = 1'b1;
            pend_data_d  = cram_dq;
            pend_ub_n_d  = cram_ub_n;
            pend_lb_n_d  = cram_lb_n;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      lat_q        <= '0;
      dq_oe_q      <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_ub_n_q  <= 1'b1;
      pend_lb_n_q  <= 1'b1;
      rd_count_q   <= '0;
      wr_count_q   <= '0;
      proto_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lat_q        <= lat_d;
      dq_oe_q      <= dq_oe_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_ub_n_q  <= pend_ub_n_d;
      pend_lb_n_q  <= pend_lb_n_d;
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
      proto_q      <= proto_d;
    end
  end

  // Store is never cleared; reset only blocks a commit in flight.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      if (!pend_ub_n_q) mem[addr_q][DATA_BITS-1:HB] <= pend_data_q[DATA_BITS-1:HB];
      if (!pend_lb_n_q) mem[addr_q][HB-1:0]         <= pend_data_q[HB-1:0];
    end
  end

  // Gating directly on cram_oe_n releases the bus in the same cycle oe_n rises.
  assign cram_dq   = (dq_oe_q && !cram_oe_n) ? mem[addr_q] : 'z;
  assign cram_wait = 1'b0;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;
  assign proto_err = proto_q;

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder
//   Directed bench for psram_responder with default parameters. The bus
//   model drives cram_dq through a tri-state with a pulldown, so a released
//   bus reads as 0.
module tb_psram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:16] cram_a;
  wire  [15:0] dq;
  logic [15:0] dq_drv;
  logic        dq_en;
  logic        adv_n, ce0_n, ce1_n, oe_n, we_n, ub_n, lb_n;
  logic        cram_wait, proto_err;
  logic [15:0] rd_count, wr_count;

  int tests = 0;
  int fails = 0;

  assign dq = dq_en ? dq_drv : 'z;
  pulldown (dq);

  always #5 clk = ~clk;

  psram_responder #(
    .ADDRESS_BITS(23), .DATA_BITS(16), .MEM_ADDR_BITS(10), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .reset(reset), .cram_a(cram_a), .cram_dq(dq),
    .cram_adv_n(adv_n), .cram_ce0_n(ce0_n), .cram_ce1_n(ce1_n),
    .cram_oe_n(oe_n), .cram_we_n(we_n), .cram_ub_n(ub_n), .cram_lb_n(lb_n),
    .cram_clk(1'b0), .cram_cre(1'b0), .cram_wait(cram_wait),
    .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle;
    ce0_n = 1'b1; ce1_n = 1'b1; adv_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    ub_n = 1'b0; lb_n = 1'b0; dq_en = 1'b0;
  endtask

  task automatic addr_phase(input logic [22:0] a, input logic wr);
    ce0_n = a[22]; ce1_n = ~a[22];
    adv_n = 1'b0; we_n = ~wr; oe_n = 1'b1;
    cram_a = a[21:16]; dq_en = 1'b1; dq_drv = a[15:0];
    tick;
  endtask

  // Address cycle, two data cycles, one deselect cycle.
  task automatic wr(input logic [22:0] a, input logic [15:0] d, input logic ub, input logic lb);
    addr_phase(a, 1'b1);
    adv_n = 1'b1; dq_drv = d; ub_n = ub; lb_n = lb;
    tick;
    tick;
    set_idle;
    tick;
  endtask

  // Address cycle, two oe_n-low cycles, one deselect cycle.
  task automatic rd(input logic [22:0] a, input logic [15:0] exp, input string tag);
    addr_phase(a, 1'b0);
    adv_n = 1'b1; dq_en = 1'b0; oe_n = 1'b0;
    #1 chk({tag, "_first_oe_z"}, {16'd0, dq}, 32'h0);
    tick;
    chk({tag, "_data"}, {16'd0, dq}, {16'd0, exp});
    tick;
    set_idle;
    #1 chk({tag, "_release_z"}, {16'd0, dq}, 32'h0);
    tick;
  endtask

  logic [15:0] sb [1024];
  logic [22:0] wa [64];
  logic [15:0] wd;

  initial begin
    set_idle;
    cram_a = '0; dq_drv = '0;
    reset = 1'b1;
    tick; tick;
    chk("reset_rd_count", {16'd0, rd_count}, 32'd0);
    chk("reset_wr_count", {16'd0, wr_count}, 32'd0);
    chk("reset_proto", {31'd0, proto_err}, 32'd0);
    chk("reset_dq_z", {16'd0, dq}, 32'd0);
    chk("wait_tied", {31'd0, cram_wait}, 32'd0);
    reset = 1'b0;
    tick;

    // basic write / read
    wr(23'h000005, 16'h1234, 1'b0, 1'b0);
    chk("wr_count_1", {16'd0, wr_count}, 32'd1);
    rd(23'h000005, 16'h1234, "rd5");
    chk("rd_count_1", {16'd0, rd_count}, 32'd1);

    // byte-masked write
    wr(23'h000007, 16'h1234, 1'b0, 1'b0);
    wr(23'h000007, 16'hABCD, 1'b1, 1'b0);
    rd(23'h000007, 16'h12CD, "rd7_lb");
    chk("wr_count_3", {16'd0, wr_count}, 32'd3);
    chk("rd_count_2", {16'd0, rd_count}, 32'd2);

    // bank-1 write aliases onto word 3
    wr(23'h400003, 16'h5A5A, 1'b0, 1'b0);
    rd(23'h000003, 16'h5A5A, "rd3_alias");
    chk("proto_clean", {31'd0, proto_err}, 32'd0);

    // both CEs low sets sticky error
    ce0_n = 1'b0; ce1_n = 1'b0;
    tick;
    set_idle;
    tick;
    chk("proto_set", {31'd0, proto_err}, 32'd1);
    rd(23'h000005, 16'h1234, "rd5_sticky");
    chk("proto_sticky", {31'd0, proto_err}, 32'd1);
    chk("rd_count_4", {16'd0, rd_count}, 32'd4);

    // reset during write data phase, deselecting in the same cycle
    wr(23'h000009, 16'h1111, 1'b0, 1'b0);
    addr_phase(23'h000009, 1'b1);
    adv_n = 1'b1; dq_drv = 16'h2222;
    tick;
    reset = 1'b1;
    set_idle;
    tick;
    reset = 1'b0;
    tick;
    chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
    chk("rst_rd_count", {16'd0, rd_count}, 32'd0);
    chk("rst_proto", {31'd0, proto_err}, 32'd0);
    rd(23'h000009, 16'h1111, "rd9_after_rst");
    rd(23'h000005, 16'h1234, "rd5_preserved");
    chk("rd_count_post_rst", {16'd0, rd_count}, 32'd2);

    // abandoned read and data-less write do not count
    addr_phase(23'h000007, 1'b0);
    set_idle;
    tick;
    chk("abandoned_rd", {16'd0, rd_count}, 32'd2);
    addr_phase(23'h000007, 1'b1);
    set_idle;
    tick;
    chk("empty_wr", {16'd0, wr_count}, 32'd0);
    rd(23'h000007, 16'h12CD, "rd7_untouched");

    // alternating random write/read against a scoreboard
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    for (int i = 0; i < 64; i++) begin
      int unsigned j;
      wa[i] = 23'($urandom());
      wd    = 16'($urandom());
      wr(wa[i], wd, 1'b0, 1'b0);
      sb[wa[i][9:0]] = wd;
      j = $urandom_range(0, i);
      rd(wa[j], sb[wa[j][9:0]], "rand");
    end
    chk("rand_wr_count", {16'd0, wr_count}, 32'd64);
    chk("rand_rd_count", {16'd0, rd_count}, 32'd64);
    chk("rand_proto", {31'd0, proto_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
